// File: rtl/pe_cmd_issuer.sv
// pe_cmd_issuer: buffers host commands in a FIFO and issues them one at a time to the
// single-cycle PE core, returning each result (or a timeout error) as a host response.
// Optional feature macro PE_CMD_CHAIN_EN: a command may take op1 from the last good result.
module pe_cmd_issuer #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [31:0] cmd_opcode,
  input  logic [31:0] cmd_op1,
  input  logic [31:0] cmd_op2,
  input  logic [31:0] cmd_op3,
  input  logic        cmd_chain,
  output logic [31:0] pe_opcode,
  output logic [31:0] pe_op1,
  output logic [31:0] pe_op2,
  output logic [31:0] pe_op3,
  output logic        pe_valid,
  input  logic [31:0] pe_result,
  input  logic        pe_result_valid,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_err,
  output logic        busy,
  output logic        stray_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT + 1);
`ifdef PE_CMD_CHAIN_EN
  localparam int EW = 129;
`else
  localparam int EW = 128;
`endif

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  // Handshakes: a command transfers on a cycle with cmd_valid && cmd_ready; a response
  // transfers on a cycle with rsp_valid && rsp_ready, and rsp_* hold until then.
  state_t        r_state;
  logic [EW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic [TW-1:0] r_wait;

  logic          w_full;
  logic          w_empty;
  logic          w_push;
  logic          w_pop;
  logic [EW-1:0] w_wr_entry;
  logic [EW-1:0] w_head;
  logic [31:0]   w_iss_op1;

  assign w_full    = (r_count == CW'(DEPTH));
  assign w_empty   = (r_count == '0);
  assign w_push    = cmd_valid && !w_full;
  assign w_pop     = !w_empty && ((r_state == S_IDLE) || ((r_state == S_RESP) && rsp_ready));
  assign cmd_ready = !w_full;
  assign busy      = !w_empty || (r_state != S_IDLE);
  assign w_head    = r_mem[r_rd_ptr];

`ifdef PE_CMD_CHAIN_EN
  logic [31:0] r_chain;
  assign w_wr_entry = {cmd_chain, cmd_opcode, cmd_op1, cmd_op2, cmd_op3};
  assign w_iss_op1  = w_head[128] ? r_chain : w_head[95:64];
`else
  logic w_unused_chain;
  assign w_unused_chain = cmd_chain;
  assign w_wr_entry     = {cmd_opcode, cmd_op1, cmd_op2, cmd_op3};
  assign w_iss_op1      = w_head[95:64];
`endif

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= w_wr_entry;
  end

  // A full FIFO never pushes, so a push and pop together leave the count unchanged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_wait    <= '0;
      pe_opcode <= '0;
      pe_op1    <= '0;
      pe_op2    <= '0;
      pe_op3    <= '0;
      pe_valid  <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
      stray_err <= 1'b0;
`ifdef PE_CMD_CHAIN_EN
      r_chain   <= '0;
`endif
    end else begin
      pe_valid <= 1'b0;
      if (pe_result_valid && (r_state != S_WAIT)) stray_err <= 1'b1;
      case (r_state)
        S_IDLE: begin
          if (!w_empty) begin
            pe_opcode <= w_head[127:96];
            pe_op1    <= w_iss_op1;
            pe_op2    <= w_head[63:32];
            pe_op3    <= w_head[31:0];
            pe_valid  <= 1'b1;
            r_state   <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_wait  <= TW'(1);
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (pe_result_valid) begin
            rsp_data  <= pe_result;
            rsp_err   <= 1'b0;
            rsp_valid <= 1'b1;
`ifdef PE_CMD_CHAIN_EN
            r_chain   <= pe_result;
`endif
            r_state   <= S_RESP;
          end else if (r_wait == TW'(TIMEOUT)) begin
            rsp_data  <= '0;
            rsp_err   <= 1'b1;
            rsp_valid <= 1'b1;
            r_state   <= S_RESP;
          end else begin
            r_wait <= r_wait + TW'(1);
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            if (!w_empty) begin
              pe_opcode <= w_head[127:96];
              pe_op1    <= w_iss_op1;
              pe_op2    <= w_head[63:32];
              pe_op3    <= w_head[31:0];
              pe_valid  <= 1'b1;
              r_state   <= S_ISSUE;
            end else begin
              r_state <= S_IDLE;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pe_cmd_issuer.sv
// tb_pe_cmd_issuer: directed bench for pe_cmd_issuer with a small single-cycle PE model
// (ADD/SUB/MUL majors answer one cycle after pe_valid; any other major never answers).
module tb_pe_cmd_issuer;

  localparam logic [31:0] OP_ADD = 32'h02100000;
  localparam logic [31:0] OP_SUB = 32'h02200000;
  localparam logic [31:0] OP_MUL = 32'h02300000;
  localparam logic [31:0] OP_BAD = 32'h00000000;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_chain;
  logic [31:0] cmd_opcode, cmd_op1, cmd_op2, cmd_op3;
  logic [31:0] pe_opcode, pe_op1, pe_op2, pe_op3;
  logic        pe_valid;
  logic [31:0] pe_result;
  logic        pe_result_valid;
  logic        rsp_valid, rsp_ready, rsp_err, busy, stray_err;
  logic [31:0] rsp_data;

  logic        m_valid = 1'b0;
  logic [31:0] m_result = '0;
  logic        inj_valid;
  logic [31:0] inj_data;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  pe_cmd_issuer #(.DEPTH(4), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_opcode(cmd_opcode), .cmd_op1(cmd_op1), .cmd_op2(cmd_op2), .cmd_op3(cmd_op3),
    .cmd_chain(cmd_chain),
    .pe_opcode(pe_opcode), .pe_op1(pe_op1), .pe_op2(pe_op2), .pe_op3(pe_op3),
    .pe_valid(pe_valid), .pe_result(pe_result), .pe_result_valid(pe_result_valid),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .busy(busy), .stray_err(stray_err)
  );

  always @(posedge clk) begin
    m_valid <= 1'b0;
    if (pe_valid) begin
      case (pe_opcode[31:20])
        12'h021: begin m_valid <= 1'b1; m_result <= pe_op1 + pe_op2; end
        12'h022: begin m_valid <= 1'b1; m_result <= pe_op1 - pe_op2; end
        12'h023: begin m_valid <= 1'b1; m_result <= pe_op1 * pe_op2; end
        default: ;
      endcase
    end
  end

  assign pe_result_valid = m_valid | inj_valid;
  assign pe_result       = inj_valid ? inj_data : m_result;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic drive_cmd(input logic [31:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic ch);
    cmd_valid  = 1'b1;
    cmd_opcode = op;
    cmd_op1    = a;
    cmd_op2    = b;
    cmd_op3    = 32'h0;
    cmd_chain  = ch;
  endtask

  task automatic test_reset;
    rst = 1'b1; cmd_valid = 1'b0; rsp_ready = 1'b0; inj_valid = 1'b0; inj_data = '0;
    cmd_opcode = '0; cmd_op1 = '0; cmd_op2 = '0; cmd_op3 = '0; cmd_chain = 1'b0;
    repeat (2) @(negedge clk);
    total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL reset_cmd_ready: got %b want 1", cmd_ready); end
    total++; if (pe_valid !== 1'b0) begin bad++; $display("FAIL reset_pe_valid: got %b want 0", pe_valid); end
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
    total++; if (rsp_data !== 32'h0) begin bad++; $display("FAIL reset_rsp_data: got %h want 0", rsp_data); end
    total++; if (rsp_err !== 1'b0) begin bad++; $display("FAIL reset_rsp_err: got %b want 0", rsp_err); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    total++; if (stray_err !== 1'b0) begin bad++; $display("FAIL reset_stray: got %b want 0", stray_err); end
    total++; if (pe_opcode !== 32'h0) begin bad++; $display("FAIL reset_pe_opcode: got %h want 0", pe_opcode); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_add_single;
    int n;
    int pulses;
    rsp_ready = 1'b1;
    drive_cmd(OP_ADD, 32'd3, 32'd5, 1'b0);
    @(negedge clk);
    cmd_valid = 1'b0;
    n = 1; pulses = 0;
    while (rsp_valid !== 1'b1 && n < 20) begin
      if (pe_valid === 1'b1) pulses++;
      @(negedge clk);
      n++;
    end
    total++; if (n != 4) begin bad++; $display("FAIL add_latency: got %0d want 4", n); end
    total++; if (pulses != 1) begin bad++; $display("FAIL add_pe_pulses: got %0d want 1", pulses); end
    total++; if (rsp_data !== 32'd8) begin bad++; $display("FAIL add_data: got %0d want 8", rsp_data); end
    total++; if (rsp_err !== 1'b0) begin bad++; $display("FAIL add_err: got %b want 0", rsp_err); end
    @(negedge clk);
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL add_rsp_drop: got %b want 0", rsp_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL add_busy_end: got %b want 0", busy); end
  endtask

  task automatic test_timeout;
    int n;
    rsp_ready = 1'b1;
    drive_cmd(OP_BAD, 32'd1, 32'd0, 1'b0);
    @(negedge clk);
    cmd_valid = 1'b0;
    n = 1;
    while (rsp_valid !== 1'b1 && n < 30) begin
      @(negedge clk);
      n++;
    end
    total++; if (n != 7) begin bad++; $display("FAIL timeout_latency: got %0d want 7", n); end
    total++; if (rsp_err !== 1'b1) begin bad++; $display("FAIL timeout_err: got %b want 1", rsp_err); end
    total++; if (rsp_data !== 32'h0) begin bad++; $display("FAIL timeout_data: got %h want 0", rsp_data); end
    total++; if (stray_err !== 1'b0) begin bad++; $display("FAIL timeout_stray: got %b want 0", stray_err); end
    @(negedge clk);
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL timeout_rsp_drop: got %b want 0", rsp_valid); end
  endtask

  task automatic test_fifo_full;
    int n;
    int extra;
    logic [31:0] e;
    rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL full_ready_before_push%0d: got %b want 1", i, cmd_ready); end
      drive_cmd(OP_ADD, 32'(i), 32'd10, 1'b0);
      @(negedge clk);
    end
    total++; if (cmd_ready !== 1'b0) begin bad++; $display("FAIL full_ready_low: got %b want 0", cmd_ready); end
    total++; if (rsp_valid !== 1'b1) begin bad++; $display("FAIL full_first_rsp_valid: got %b want 1", rsp_valid); end
    drive_cmd(OP_ADD, 32'd100, 32'd100, 1'b0);
    for (int i = 0; i < 3; i++) begin
      total++; if (cmd_ready !== 1'b0) begin bad++; $display("FAIL full_hold_ready%0d: got %b want 0", i, cmd_ready); end
      total++; if (rsp_valid !== 1'b1) begin bad++; $display("FAIL full_hold_valid%0d: got %b want 1", i, rsp_valid); end
      total++; if (rsp_data !== 32'd10) begin bad++; $display("FAIL full_hold_data%0d: got %0d want 10", i, rsp_data); end
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL full_ready_after_pop: got %b want 1", cmd_ready); end
    cmd_valid = 1'b0;
    exp_q = {32'd11, 32'd12, 32'd13, 32'd14};
    n = 0;
    while (exp_q.size() > 0 && n < 40) begin
      @(negedge clk);
      n++;
      if (rsp_valid === 1'b1) begin
        e = exp_q.pop_front();
        total++; if (rsp_data !== e) begin bad++; $display("FAIL full_order: got %0d want %0d", rsp_data, e); end
      end
    end
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL full_missing_rsp: got %0d left want 0", exp_q.size()); end
    extra = 0;
    repeat (8) begin
      @(negedge clk);
      if (rsp_valid === 1'b1) extra++;
    end
    total++; if (extra != 0) begin bad++; $display("FAIL full_extra_rsp: got %0d want 0", extra); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL full_busy_end: got %b want 0", busy); end
  endtask

  task automatic test_back_to_back;
    int n;
    int last;
    logic [31:0] e;
    rsp_ready = 1'b1;
    exp_q = {32'd2, 32'd5, 32'd42};
    drive_cmd(OP_ADD, 32'd1, 32'd1, 1'b0); @(negedge clk);
    drive_cmd(OP_SUB, 32'd9, 32'd4, 1'b0); @(negedge clk);
    drive_cmd(OP_MUL, 32'd6, 32'd7, 1'b0); @(negedge clk);
    cmd_valid = 1'b0;
    n = 0; last = -1;
    while (exp_q.size() > 0 && n < 40) begin
      @(negedge clk);
      n++;
      if (rsp_valid === 1'b1) begin
        e = exp_q.pop_front();
        total++; if (rsp_data !== e) begin bad++; $display("FAIL b2b_data: got %0d want %0d", rsp_data, e); end
        if (last >= 0) begin
          total++; if (n - last != 3) begin bad++; $display("FAIL b2b_spacing: got %0d want 3", n - last); end
        end
        last = n;
      end
    end
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL b2b_missing_rsp: got %0d left want 0", exp_q.size()); end
    repeat (2) @(negedge clk);
  endtask

`ifdef PE_CMD_CHAIN_EN
  task automatic test_chain;
    int n;
    int npe;
    logic [31:0] e;
    rsp_ready = 1'b1;
    exp_q = {32'd5, 32'd20};
    drive_cmd(OP_ADD, 32'd2, 32'd3, 1'b0); @(negedge clk);
    drive_cmd(OP_MUL, 32'd99, 32'd4, 1'b1); @(negedge clk);
    cmd_valid = 1'b0; cmd_chain = 1'b0;
    n = 0; npe = 0;
    while (exp_q.size() > 0 && n < 40) begin
      @(negedge clk);
      n++;
      if (pe_valid === 1'b1) begin
        if (npe == 1) begin
          total++; if (pe_op1 !== 32'd5) begin bad++; $display("FAIL chain_op1: got %0d want 5", pe_op1); end
        end
        npe++;
      end
      if (rsp_valid === 1'b1) begin
        e = exp_q.pop_front();
        total++; if (rsp_data !== e) begin bad++; $display("FAIL chain_data: got %0d want %0d", rsp_data, e); end
      end
    end
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL chain_missing_rsp: got %0d left want 0", exp_q.size()); end
    repeat (2) @(negedge clk);
  endtask
`endif

  task automatic test_reset_in_wait;
    int seen;
    rsp_ready = 1'b1;
    drive_cmd(OP_BAD, 32'd7, 32'd0, 1'b0);
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (2) @(negedge clk);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL rstw_busy_before: got %b want 1", busy); end
    rst = 1'b1;
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rstw_busy_in_reset: got %b want 0", busy); end
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL rstw_valid_in_reset: got %b want 0", rsp_valid); end
    total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL rstw_ready_in_reset: got %b want 1", cmd_ready); end
    @(negedge clk);
    rst = 1'b0;
    inj_valid = 1'b1; inj_data = 32'hDEADBEEF;
    @(negedge clk);
    inj_valid = 1'b0;
    total++; if (stray_err !== 1'b1) begin bad++; $display("FAIL rstw_stray: got %b want 1", stray_err); end
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL rstw_rsp_valid: got %b want 0", rsp_valid); end
    total++; if (rsp_data !== 32'h0) begin bad++; $display("FAIL rstw_rsp_data: got %h want 0", rsp_data); end
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (rsp_valid === 1'b1) seen++;
    end
    total++; if (seen != 0) begin bad++; $display("FAIL rstw_no_rsp: got %0d want 0", seen); end
    total++; if (stray_err !== 1'b1) begin bad++; $display("FAIL rstw_stray_sticky: got %b want 1", stray_err); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rstw_busy_end: got %b want 0", busy); end
  endtask

  initial begin
    test_reset();
    test_add_single();
    test_timeout();
    test_fifo_full();
    test_back_to_back();
`ifdef PE_CMD_CHAIN_EN
    test_chain();
`endif
    test_reset_in_wait();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pe_cmd_issuer.md
Name: pe_cmd_issuer

Overview:
Command-side driver for the single-cycle PE core. It buffers host commands (opcode plus three operands) in a FIFO and issues them to the PE one at a time. It captures each PE result, or times out when the PE returns nothing, which happens for unsupported major opcodes. Each result goes back to the host as a response with a valid/ready handshake and an error flag. It sits between the host/sequencer and the PE core's opcode/op1/op2/op3/valid_in and result_out/result_valid interface.

Parameters:
DEPTH, 4, command FIFO entries (power of 2, >=2)
TIMEOUT, 4, WAIT cycles without pe_result_valid before the command is flagged as error (>=2)

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous, active-high
cmd_valid  input  1  host command valid
cmd_ready  output  1  FIFO can accept; equals !full
cmd_opcode  input  32  command opcode
cmd_op1  input  32  operand 1
cmd_op2  input  32  operand 2
cmd_op3  input  32  operand 3
cmd_chain  input  1  replace op1 with previous result (only with the optional feature)
pe_opcode  output  32  to PE opcode
pe_op1  output  32  to PE op1
pe_op2  output  32  to PE op2
pe_op3  output  32  to PE op3
pe_valid  output  1  to PE valid_in
pe_result  input  32  from PE result_out
pe_result_valid  input  1  from PE result_valid
rsp_valid  output  1  response valid
rsp_ready  input  1  host accepts response
rsp_data  output  32  result (0 on error)
rsp_err  output  1  timeout error
busy  output  1  FIFO non-empty or state != IDLE
stray_err  output  1  sticky; set by pe_result_valid outside WAIT

Behaviour:
- Reset (asynchronous, active-high):
  - FIFO empty; state IDLE.
  - All outputs 0 except cmd_ready=1.
  - In-flight command and response are discarded. A PE result arriving after reset sets stray_err.
- FIFO:
  - Push when cmd_valid && cmd_ready.
  - Pop at the edge that enters ISSUE.
  - Push and pop in the same cycle are both allowed when not full. When full, no push happens (cmd_ready=0), even if a pop occurs that cycle.
  - A pop never happens from an empty FIFO; a same-cycle push into an empty FIFO is issued on a later cycle.
  - Pointers wrap modulo DEPTH. A count of log2(DEPTH)+1 bits distinguishes full from empty.
- State machine (IDLE, ISSUE, WAIT, RESP):
  - IDLE -> ISSUE when the FIFO is non-empty. The FIFO head is registered into pe_opcode/op1/op2/op3 on the same edge.
  - ISSUE: pe_valid=1 for exactly one cycle. Next state WAIT; wait counter set to 1.
  - WAIT, pe_result_valid=1: capture rsp_data=pe_result, rsp_err=0, go to RESP.
  - WAIT, no result and counter==TIMEOUT: rsp_data=0, rsp_err=1, go to RESP. Otherwise the counter increments.
  - With a compliant PE, the result arrives in the first WAIT cycle.
  - RESP: rsp_valid held high; rsp_data/rsp_err are stable until rsp_ready. On the handshake, go to ISSUE if the FIFO is non-empty (head loaded on that edge), otherwise IDLE.
- Throughput and latency:
  - Peak rate is 1 command per 3 cycles.
  - With an empty FIFO, command accept to rsp_valid is 4 cycles.
- pe_valid is low in every state except ISSUE. pe_op* hold their last value (don't-care when pe_valid=0).
- Only one command is outstanding at a time, so results cannot be misattributed.
- stray_err:
  - Set when pe_result_valid=1 in IDLE, ISSUE or RESP.
  - Cleared only by reset.
  - The stray data is ignored.

Optional Feature:
PE_CMD_CHAIN_EN
- Defined: a cmd_chain bit is stored per FIFO entry. On issue, if that bit is set, pe_op1 = the last non-error rsp_data, held in a register that resets to 0 and updates on each non-error capture. Error responses do not update it.
- Undefined: cmd_chain is ignored, not stored, and the chain register is absent.

Test Plan:
- Reset, then push opcode 32'h02100000 (ADD), op1=3, op2=5, rsp_ready=1 -> pe_valid pulses once; rsp_valid 4 cycles after accept; rsp_data=8, rsp_err=0.
- Push opcode 32'h00000000 (invalid major), op1=1 -> no PE result; after TIMEOUT=4 WAIT cycles: rsp_valid=1, rsp_err=1, rsp_data=0, stray_err=0.
- Hold rsp_ready=0, push 5 ADD commands -> cmd_ready=0 after 4 more accepts, with the first command in RESP. Release rsp_ready -> responses in push order; cmd_ready returns 1 after the first pop.
- Back-to-back: 3 commands (ADD 1+1, SUB 9-4 with 32'h02200000, MUL 6*7 with 32'h02300000), rsp_ready=1 -> rsp_data 2, 5, 42, spaced 3 cycles apart.
- Assert rst during WAIT; PE result_valid arrives the next cycle -> outputs reset; stray_err=1; no rsp_valid.
- With PE_CMD_CHAIN_EN: ADD 2+3, then MUL with chain=1, op2=4 -> second pe_op1=5, rsp_data=20.
